// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-channel FSM states.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HAVE_ADDR = 3'd1,
    HAVE_DATA = 3'd2,
    WRITE     = 3'd3,
    RESP      = 3'd4
  } write_state_e;

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Byte address to word index conversion plus range check against the register count.
module axi4_lite_addr_decode #(
  parameter int ADDRESS_SIZE = 32,
  parameter int REGISTERS    = 1
) (
  input  logic [ADDRESS_SIZE-1:0] byte_address,
  output logic [ADDRESS_SIZE-1:0] word_index,
  output logic                    in_range
);

  // Low two address bits select a byte lane and never affect the word index.
  assign word_index = byte_address >> 2;
  assign in_range   = ({1'b0, word_index} < (ADDRESS_SIZE + 1)'(REGISTERS));

endmodule

// File: rtl/axi4_lite_write_manager.sv
// AXI4-Lite write subordinate: collects AW and W in either order, pulses one register write, answers on B.
module axi4_lite_write_manager
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int REGISTERS    = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_clk_ni,
  input  logic [ADDRESS_SIZE-1:0]  write_address_i,
  input  logic                     write_address_valid_i,
  output logic                     write_address_ready_o,
  input  logic [DATA_SIZE-1:0]     write_data_i,
  input  logic [DATA_SIZE/8-1:0]   write_strobe_i,
  input  logic                     write_data_valid_i,
  output logic                     write_data_ready_o,
  output logic [1:0]               write_response_o,
  output logic                     write_response_valid_o,
  input  logic                     write_response_ready_i,
  output logic [ADDRESS_SIZE-1:0]  register_address_o,
  output logic [DATA_SIZE-1:0]     register_data_o,
  output logic [DATA_SIZE/8-1:0]   register_strobe_o,
  output logic                     register_write_enable_o,
  output logic [2:0]               state_o
);

  // Handshake rule: a channel transfers on a rising edge where valid and ready are both 1;
  // readies come straight from flops, so they never depend combinationally on any valid.

  write_state_e state_q, state_d;

  logic                    aw_ready_q;
  logic                    w_ready_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0]    data_q;
  logic [DATA_SIZE/8-1:0]  strb_q;
  logic [1:0]              resp_q;

  logic                    aw_hs;
  logic                    w_hs;
  logic [ADDRESS_SIZE-1:0] word_index;
  logic                    in_range;

  assign aw_hs = write_address_valid_i & aw_ready_q;
  assign w_hs  = write_data_valid_i & w_ready_q;

  axi4_lite_addr_decode #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .REGISTERS    (REGISTERS)
  ) u_addr_decode (
    .byte_address (addr_q),
    .word_index   (word_index),
    .in_range     (in_range)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = WRITE;
        else if (aw_hs)    state_d = HAVE_ADDR;
        else if (w_hs)     state_d = HAVE_DATA;
      end
      HAVE_ADDR: if (w_hs)  state_d = WRITE;
      HAVE_DATA: if (aw_hs) state_d = WRITE;
      WRITE:     state_d = RESP;
      RESP:      if (write_response_ready_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      state_q    <= IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      resp_q     <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      // Readies track the state being entered, which also holds them low for the first cycle out of reset.
      aw_ready_q <= (state_d == IDLE) || (state_d == HAVE_DATA);
      w_ready_q  <= (state_d == IDLE) || (state_d == HAVE_ADDR);
      if (aw_hs) addr_q <= write_address_i;
      if (w_hs) begin
        data_q <= write_data_i;
        strb_q <= write_strobe_i;
      end
      if (state_q == WRITE) resp_q <= in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign write_address_ready_o   = aw_ready_q;
  assign write_data_ready_o      = w_ready_q;
  assign write_response_o        = resp_q;
  assign write_response_valid_o  = (state_q == RESP);
  assign register_address_o      = word_index;
  assign register_data_o         = data_q;
  assign register_strobe_o       = strb_q;
  assign register_write_enable_o = (state_q == WRITE) && in_range;
  assign state_o                 = state_q;

endmodule
